// File: rtl/serial_pkg.sv
// serial_pkg: shared serial link state type, idle line level and parity helper
package serial_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} serial_tx_state_t;
  localparam logic SERIAL_IDLE_LEVEL = 1'b0;
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction
endpackage

// File: rtl/serial_tx_8bit_tick.sv
// bit_tick_gen: bit-period counter, tick on the last clock of each serial bit
module bit_tick_gen #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [TW-1:0] tick_cnt;
  assign tick = tick_cnt == TW'(CLKS_PER_BIT - 1);
  // clear pins the phase at zero between frames so bit 0 gets a full period
  always_ff @(posedge clk) tick_cnt <= (rst || clear || tick) ? '0 : tick_cnt + TW'(1);
endmodule

// File: rtl/serial_tx_8bit.sv
// serial_tx_8bit: LSB-first serial transmitter with per-bit strobe; SERIAL_TX_PARITY_EN appends an even-parity bit
module serial_tx_8bit
  import serial_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sdo,
  output logic             sdo_en,
  output logic             busy,
  output logic             frame_done
);
  localparam int BW = $clog2(WIDTH + 1);
`ifdef SERIAL_TX_PARITY_EN
  localparam serial_tx_state_t AFTER_SHIFT = PARITY;
`else
  localparam serial_tx_state_t AFTER_SHIFT = DONE;
`endif
  serial_tx_state_t state, state_nx;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0] bit_cnt;
  logic tick, load, last_bit;
`ifdef SERIAL_TX_PARITY_EN
  logic par_q;
`endif
  bit_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(!busy),
    .tick (tick)
  );
  assign din_ready  = state == IDLE && !rst;
  assign load       = din_valid && din_ready;
  assign last_bit   = bit_cnt == BW'(WIDTH - 1);
  assign busy       = state == SHIFT || state == PARITY;
  assign frame_done = state == DONE;
  assign sdo_en     = busy && tick;
`ifdef SERIAL_TX_PARITY_EN
  assign sdo = state == SHIFT ? shreg[0] : state == PARITY ? par_q : SERIAL_IDLE_LEVEL;
`else
  assign sdo = state == SHIFT ? shreg[0] : SERIAL_IDLE_LEVEL;
`endif
  // next state: each bit ends on its tick; DONE lasts exactly one cycle
  always_comb begin
    state_nx = state;
    if (state == IDLE && load) state_nx = SHIFT;
    else if (state == SHIFT && tick && last_bit) state_nx = AFTER_SHIFT;
`ifdef SERIAL_TX_PARITY_EN
    else if (state == PARITY && tick) state_nx = DONE;
`endif
    else if (state == DONE) state_nx = IDLE;
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // datapath: capture the word at the handshake, shift one bit per strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= din;
      bit_cnt <= '0;
    end else if (state == SHIFT && tick) begin
      shreg   <= shreg >> 1;
      bit_cnt <= bit_cnt + BW'(1);
    end
  end
`ifdef SERIAL_TX_PARITY_EN
  // parity is taken from the captured word since the shifter empties itself
  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else if (load) par_q <= even_parity(64'(din));
  end
`endif
endmodule

// File: tb/tb_serial_tx_8bit.sv
// tb_serial_tx_8bit: directed checks of the serial transmitter at 1 and 4 clocks per bit
module tb_serial_tx_8bit;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] din_1 = '0, din_4 = '0;
  logic din_valid_1 = 1'b0, din_valid_4 = 1'b0;
  logic din_ready_1, sdo_1, sdo_en_1, busy_1, frame_done_1;
  logic din_ready_4, sdo_4, sdo_en_4, busy_4, frame_done_4;
  logic [7:0] rx_1 = '0, rx_4 = '0;
  logic last_1 = 1'b0;
  int n_en_1 = 0, n_done_1 = 0, n_en_4 = 0;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  serial_tx_8bit #(.WIDTH(8), .CLKS_PER_BIT(1)) u1 (
    .clk(clk), .rst(rst), .din(din_1), .din_valid(din_valid_1), .din_ready(din_ready_1),
    .sdo(sdo_1), .sdo_en(sdo_en_1), .busy(busy_1), .frame_done(frame_done_1)
  );
  serial_tx_8bit #(.WIDTH(8), .CLKS_PER_BIT(4)) u4 (
    .clk(clk), .rst(rst), .din(din_4), .din_valid(din_valid_4), .din_ready(din_ready_4),
    .sdo(sdo_4), .sdo_en(sdo_en_4), .busy(busy_4), .frame_done(frame_done_4)
  );
  // receiving right-shift SIPOs clocked by the strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_1 <= '0;
      rx_4 <= '0;
    end else begin
      if (sdo_en_1) begin
        rx_1   <= {sdo_1, rx_1[7:1]};
        last_1 <= sdo_1;
        n_en_1 <= n_en_1 + 1;
      end
      if (sdo_en_4) begin
        rx_4   <= {sdo_4, rx_4[7:1]};
        n_en_4 <= n_en_4 + 1;
      end
      if (frame_done_1) n_done_1 <= n_done_1 + 1;
    end
  end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic frame_1(input logic [7:0] word, input logic [7:0] next_word, input logic hold, input string tag);
    int en0;
    logic b;
    logic [7:0] exp_rx;
    en0 = n_en_1;
`ifdef SERIAL_TX_PARITY_EN
    exp_rx = {^word, word[7:1]};
`else
    exp_rx = word;
`endif
    total++;
    if (din_ready_1 !== 1'b1) $display("FAIL %s_ready got %b exp 1", tag, din_ready_1);
    else passed++;
    din_1 = word;
    din_valid_1 = 1'b1;
    step();
    din_valid_1 = hold;
    for (int k = 0; k < NB; k++) begin
      b = (k < 8) ? word[k] : ^word;
      din_1 = (hold && k == NB - 1) ? next_word : 8'($urandom);
      total++;
      if ({sdo_1, sdo_en_1, busy_1, frame_done_1, din_ready_1} !== {b, 4'b1100})
        $display("FAIL %s_bit%0d {sdo,en,busy,done,ready} got %b exp %b", tag, k,
                 {sdo_1, sdo_en_1, busy_1, frame_done_1, din_ready_1}, {b, 4'b1100});
      else passed++;
      step();
    end
    total++;
    if ({frame_done_1, busy_1, din_ready_1, sdo_en_1, sdo_1} !== 5'b10000)
      $display("FAIL %s_done {done,busy,ready,en,sdo} got %b exp 10000", tag,
               {frame_done_1, busy_1, din_ready_1, sdo_en_1, sdo_1});
    else passed++;
    total++;
    if (rx_1 !== exp_rx) $display("FAIL %s_rx got %h exp %h", tag, rx_1, exp_rx);
    else passed++;
    total++;
    if (n_en_1 - en0 !== NB) $display("FAIL %s_strobes got %0d exp %0d", tag, n_en_1 - en0, NB);
    else passed++;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    din_1 = 8'hFF;
    din_4 = 8'hFF;
    din_valid_1 = 1'b1;
    din_valid_4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({sdo_en_1, sdo_1, busy_1, din_ready_1, frame_done_1} !== 5'b0)
        $display("FAIL reset_u1_c%0d got %b exp 00000", i, {sdo_en_1, sdo_1, busy_1, din_ready_1, frame_done_1});
      else passed++;
      total++;
      if ({sdo_en_4, sdo_4, busy_4, din_ready_4, frame_done_4} !== 5'b0)
        $display("FAIL reset_u4_c%0d got %b exp 00000", i, {sdo_en_4, sdo_4, busy_4, din_ready_4, frame_done_4});
      else passed++;
    end
    rst = 1'b0;
    din_valid_1 = 1'b0;
    din_valid_4 = 1'b0;
    #1;
    total++;
    if ({din_ready_1, din_ready_4} !== 2'b11) $display("FAIL reset_release_ready got %b exp 11", {din_ready_1, din_ready_4});
    else passed++;
    step(4);
    total++;
    if ({busy_1, busy_4, n_en_1 != 0, n_en_4 != 0} !== 4'b0)
      $display("FAIL reset_no_frame got busy %b%b strobes %0d/%0d exp idle", busy_1, busy_4, n_en_1, n_en_4);
    else passed++;
  endtask
  task automatic test_basic();
    frame_1(8'hA5, 8'h00, 1'b0, "basic");
    step();
    total++;
    if ({din_ready_1, frame_done_1} !== 2'b10) $display("FAIL basic_after got %b exp 10", {din_ready_1, frame_done_1});
    else passed++;
  endtask
  task automatic test_slow();
    logic [7:0] word;
    logic b;
    int en0;
    word = 8'h3C;
    en0 = n_en_4;
    total++;
    if (din_ready_4 !== 1'b1) $display("FAIL slow_ready got %b exp 1", din_ready_4);
    else passed++;
    din_4 = word;
    din_valid_4 = 1'b1;
    step();
    din_valid_4 = 1'b0;
    for (int k = 0; k < NB; k++) begin
      b = (k < 8) ? word[k] : ^word;
      for (int t = 0; t < 4; t++) begin
        din_4 = 8'($urandom);
        total++;
        if ({sdo_4, sdo_en_4, busy_4, frame_done_4} !== {b, t == 3, 2'b10})
          $display("FAIL slow_bit%0d_t%0d {sdo,en,busy,done} got %b exp %b", k, t,
                   {sdo_4, sdo_en_4, busy_4, frame_done_4}, {b, t == 3, 2'b10});
        else passed++;
        step();
      end
    end
    total++;
    if ({frame_done_4, busy_4, din_ready_4} !== 3'b100)
      $display("FAIL slow_done {done,busy,ready} got %b exp 100", {frame_done_4, busy_4, din_ready_4});
    else passed++;
`ifndef SERIAL_TX_PARITY_EN
    total++;
    if (rx_4 !== word) $display("FAIL slow_rx got %h exp %h", rx_4, word);
    else passed++;
`endif
    total++;
    if (n_en_4 - en0 !== NB) $display("FAIL slow_strobes got %0d exp %0d", n_en_4 - en0, NB);
    else passed++;
    step();
    total++;
    if (din_ready_4 !== 1'b1) $display("FAIL slow_after_ready got %b exp 1", din_ready_4);
    else passed++;
  endtask
  task automatic test_back_to_back();
    frame_1(8'h01, 8'hFE, 1'b1, "b2b_a");
    step();
    frame_1(8'hFE, 8'h00, 1'b0, "b2b_b");
    step();
  endtask
  task automatic test_reset_mid();
    int d0;
    d0 = n_done_1;
    din_1 = 8'h96;
    din_valid_1 = 1'b1;
    step();
    din_valid_1 = 1'b0;
    step(3);
    rst = 1'b1;
    step();
    total++;
    if ({busy_1, sdo_1, sdo_en_1, frame_done_1, din_ready_1} !== 5'b0)
      $display("FAIL midrst_idle got %b exp 00000", {busy_1, sdo_1, sdo_en_1, frame_done_1, din_ready_1});
    else passed++;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({sdo_en_1, frame_done_1, din_ready_1} !== 3'b001)
        $display("FAIL midrst_quiet_c%0d {en,done,ready} got %b exp 001", i, {sdo_en_1, frame_done_1, din_ready_1});
      else passed++;
      step();
    end
    total++;
    if (n_done_1 !== d0) $display("FAIL midrst_no_done got %0d exp %0d", n_done_1, d0);
    else passed++;
    frame_1(8'h5A, 8'h00, 1'b0, "midrst_next");
    step();
  endtask
`ifdef SERIAL_TX_PARITY_EN
  task automatic test_parity();
    frame_1(8'h07, 8'h00, 1'b0, "par07");
    total++;
    if (last_1 !== 1'b1) $display("FAIL par07_bit got %b exp 1", last_1);
    else passed++;
    step();
    frame_1(8'h03, 8'h00, 1'b0, "par03");
    total++;
    if (last_1 !== 1'b0) $display("FAIL par03_bit got %b exp 0", last_1);
    else passed++;
    step();
  endtask
`endif
  initial begin
    test_reset();
    test_basic();
    test_slow();
    test_back_to_back();
    test_reset_mid();
`ifdef SERIAL_TX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
